axi4_mem_slave: RTL and testbench

Parametrised AXI4 memory slave, the next generation of the single-outstanding memory slave. It supports configurable data, address and ID widths and memory depth. Write beats stream straight into byte-addressed storage under WSTRB with no burst staging buffer. It adds WRAP bursts, narrow transfers and SLVERR reporting, and runs independent read and write engines concurrently. It sits behind the interconnect as the memory endpoint used by the AXI testbench.

---
 rtl/axi_mem_pkg.sv | 37 +++
 rtl/axi4_mem_slave_if.sv | 70 +++++++
 rtl/axi_burst_addr.sv | 51 +++++
 rtl/axi4_mem_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types and width constants for the AXI4 memory slave and its
// burst address helper.
package axi_mem_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [BURST_W-1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // Legal WRAP burst lengths are 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus bundle (AW/W/B/AR/R channels) between a master and the memory slave.
interface axi4_mem_slave_if
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) ();

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_W-1:0]        awlen;
  logic [SIZE_W-1:0]       awsize;
  logic [BURST_W-1:0]      awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [RESP_W-1:0]       bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [LEN_W-1:0]        arlen;
  logic [SIZE_W-1:0]       arsize;
  logic [BURST_W-1:0]      arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_W-1:0]       rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational burst helper: next beat address, per-beat error/out-of-range
// flags and last-beat detect for one AXI direction.
module axi_burst_addr
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 1024
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_W-1:0]      len,
  input  logic [SIZE_W-1:0]     size,
  input  logic [BURST_W-1:0]    burst,
  input  logic [LEN_W-1:0]      beat,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  oob,
  output logic                  err,
  output logic                  last
);

  localparam logic [SIZE_W-1:0]     MAX_SIZE  = SIZE_W'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] size_bytes;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_addr;
  logic                  wrap_bad;

  always_comb begin
    size_bytes = ONE << size;
    wrap_bytes = (ADDR_WIDTH'(len) + ONE) * size_bytes;
    incr_addr  = (addr & ~(size_bytes - ONE)) + size_bytes;
    wrap_addr  = (addr & ~(wrap_bytes - ONE)) | ((addr + size_bytes) & (wrap_bytes - ONE));

    // Reserved burst encoding falls through to INCR stepping.
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = wrap_addr;
      default: next_addr = incr_addr;
    endcase

    wrap_bad = (burst == WRAP) &&
               (!wrap_len_ok(len) || ((addr & (size_bytes - ONE)) != '0));
    oob      = (addr >= MEM_LIMIT);
    err      = oob || (size > MAX_SIZE) || (burst == 2'b11) || wrap_bad;
    last     = (beat == len);
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave with independent read and write engines over a
// byte-lane RAM; supports FIXED/INCR/WRAP, narrow beats and SLVERR.
module axi4_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 1024
) (
  input  logic ACLK,
  input  logic ARESETn,
  axi4_mem_slave_if.slave s_axi
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int MEM_WORDS = MEM_BYTES / NB;
  localparam int WORD_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int OFF       = $clog2(NB);

  // ---------------- write engine ----------------
  wstate_e               wstate_reg, wstate_next;
  logic [ID_WIDTH-1:0]   w_id_reg;
  logic [ADDR_WIDTH-1:0] w_addr_reg;
  logic [LEN_W-1:0]      w_len_reg;
  logic [SIZE_W-1:0]     w_size_reg;
  logic [BURST_W-1:0]    w_burst_reg;
  logic [LEN_W-1:0]      w_beat_reg;
  logic                  w_err_reg;

  logic                  aw_rdy, w_rdy, b_vld;
  logic                  aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] w_next;
  logic                  w_oob, w_err, w_last;
  logic                  wr_en;
  logic [WORD_AW-1:0]    wr_idx;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_wr_addr (
    .addr      (w_addr_reg),
    .len       (w_len_reg),
    .size      (w_size_reg),
    .burst     (w_burst_reg),
    .beat      (w_beat_reg),
    .next_addr (w_next),
    .oob       (w_oob),
    .err       (w_err),
    .last      (w_last)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) wstate_reg <= W_IDLE;
    else          wstate_reg <= wstate_next;
  end

  // Ready is gated by reset so nothing is accepted while ARESETn is low.
  always_comb begin
    wstate_next = wstate_reg;
    aw_rdy      = 1'b0;
    w_rdy       = 1'b0;
    b_vld       = 1'b0;
    case (wstate_reg)
      W_IDLE: begin
        aw_rdy = ARESETn;
        if (ARESETn && s_axi.awvalid) wstate_next = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s_axi.wvalid && w_last) wstate_next = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axi.bready) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  assign aw_hs  = aw_rdy && s_axi.awvalid;
  assign w_hs   = w_rdy && s_axi.wvalid;
  assign wr_en  = w_hs && !w_oob;
  assign wr_idx = WORD_AW'(w_addr_reg >> OFF);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_size_reg  <= '0;
      w_burst_reg <= '0;
      w_beat_reg  <= '0;
      w_err_reg   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id_reg    <= s_axi.awid;
        w_addr_reg  <= s_axi.awaddr;
        w_len_reg   <= s_axi.awlen;
        w_size_reg  <= s_axi.awsize;
        w_burst_reg <= s_axi.awburst;
        w_beat_reg  <= '0;
        w_err_reg   <= 1'b0;
      end
      if (w_hs) begin
        w_addr_reg <= w_next;
        w_beat_reg <= w_beat_reg + LEN_W'(1);
        w_err_reg  <= w_err_reg | w_err | (s_axi.wlast != w_last);
      end
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bid     = w_id_reg;
  assign s_axi.bresp   = (b_vld && w_err_reg) ? SLVERR : OKAY;

  // ---------------- read engine ----------------
  rstate_e               rstate_reg, rstate_next;
  logic [ID_WIDTH-1:0]   r_id_reg;
  logic [LEN_W-1:0]      r_len_reg;
  logic [SIZE_W-1:0]     r_size_reg;
  logic [BURST_W-1:0]    r_burst_reg;
  logic [LEN_W-1:0]      r_beat_reg;
  logic [ADDR_WIDTH-1:0] r_next_reg;
  logic [RESP_W-1:0]     rresp_reg;
  logic                  rzero_reg;

  logic                  ar_rdy, r_vld;
  logic                  ar_hs, r_hs, rd_en, r_idle;
  logic [ADDR_WIDTH-1:0] r_addr_in, r_next;
  logic [LEN_W-1:0]      r_len_in, r_beat_in;
  logic [SIZE_W-1:0]     r_size_in;
  logic [BURST_W-1:0]    r_burst_in;
  logic                  r_oob, r_err, r_last;
  logic [WORD_AW-1:0]    rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // The helper looks at the address being fetched (AR address when idle,
  // prefetch pointer otherwise) but at the beat currently presented on R.
  assign r_idle     = (rstate_reg == R_IDLE);
  assign r_addr_in  = r_idle ? s_axi.araddr  : r_next_reg;
  assign r_len_in   = r_idle ? s_axi.arlen   : r_len_reg;
  assign r_size_in  = r_idle ? s_axi.arsize  : r_size_reg;
  assign r_burst_in = r_idle ? s_axi.arburst : r_burst_reg;
  assign r_beat_in  = r_idle ? '0 : r_beat_reg;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_rd_addr (
    .addr      (r_addr_in),
    .len       (r_len_in),
    .size      (r_size_in),
    .burst     (r_burst_in),
    .beat      (r_beat_in),
    .next_addr (r_next),
    .oob       (r_oob),
    .err       (r_err),
    .last      (r_last)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rstate_reg <= R_IDLE;
    else          rstate_reg <= rstate_next;
  end

  always_comb begin
    rstate_next = rstate_reg;
    ar_rdy      = 1'b0;
    r_vld       = 1'b0;
    case (rstate_reg)
      R_IDLE: begin
        ar_rdy = ARESETn;
        if (ARESETn && s_axi.arvalid) rstate_next = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (s_axi.rready && r_last) rstate_next = R_IDLE;
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  assign ar_hs  = ar_rdy && s_axi.arvalid;
  assign r_hs   = r_vld && s_axi.rready;
  assign rd_en  = ar_hs || (r_hs && !r_last);
  assign rd_idx = WORD_AW'(r_addr_in >> OFF);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_id_reg    <= '0;
      r_len_reg   <= '0;
      r_size_reg  <= '0;
      r_burst_reg <= '0;
      r_beat_reg  <= '0;
      r_next_reg  <= '0;
      rresp_reg   <= OKAY;
      rzero_reg   <= 1'b1;
    end else begin
      if (ar_hs) begin
        r_id_reg    <= s_axi.arid;
        r_len_reg   <= s_axi.arlen;
        r_size_reg  <= s_axi.arsize;
        r_burst_reg <= s_axi.arburst;
        r_beat_reg  <= '0;
      end else if (r_hs && !r_last) begin
        r_beat_reg <= r_beat_reg + LEN_W'(1);
      end
      if (rd_en) begin
        r_next_reg <= r_next;
        rresp_reg  <= r_err ? SLVERR : OKAY;
        rzero_reg  <= r_oob;
      end
    end
  end

  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rlast   = r_vld && r_last;
  assign s_axi.rid     = r_id_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rdata   = rzero_reg ? '0 : rd_word;

  // ---------------- storage: one byte-wide RAM per lane ----------------
  // Read and write share the clock edge, so a colliding read sees old data.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] ram [MEM_WORDS];
      logic [7:0] q_reg;

      always_ff @(posedge ACLK) begin
        if (wr_en && s_axi.wstrb[gi]) ram[wr_idx] <= s_axi.wdata[gi*8 +: 8];
        if (rd_en) q_reg <= ram[rd_idx];
      end

      assign rd_word[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: bursts, wrap, strobes, errors,
// concurrency with read stalls, and reset in the middle of a read.
module tb_axi4_mem_slave;
  import axi_mem_pkg::*;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  logic [31:0] wd    [16];
  logic [31:0] exp_d [16];
  logic [1:0]  exp_r [16];

  axi4_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) s ();

  axi4_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (4),
    .MEM_BYTES  (1024)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi   (s)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] strb, input bit bad_last, input logic [1:0] exp_resp);
    int n;
    s.awid = id; s.awaddr = addr; s.awlen = 8'(len);
    s.awsize = size; s.awburst = burst; s.awvalid = 1'b1;
    n = 0;
    while (!s.awready && n < 20) begin @(negedge ACLK); n++; end
    chk("aw_ready", 32'(s.awready), 1);
    @(negedge ACLK);
    s.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s.wvalid = 1'b1; s.wdata = wd[i]; s.wstrb = strb;
      s.wlast  = (i == len) ^ (bad_last && i == 0);
      n = 0;
      while (!s.wready && n < 20) begin @(negedge ACLK); n++; end
      chk("w_ready", 32'(s.wready), 1);
      @(negedge ACLK);
    end
    s.wvalid = 1'b0; s.wlast = 1'b0;
    chk("b_valid", 32'(s.bvalid), 1);
    chk("b_id", 32'(s.bid), 32'(id));
    chk("b_resp", 32'(s.bresp), 32'(exp_resp));
    s.bready = 1'b1;
    @(negedge ACLK);
    s.bready = 1'b0;
    chk("b_done", 32'(s.bvalid), 0);
    chk("aw_ready_b2b", 32'(s.awready), 1);
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int n;
    s.arid = id; s.araddr = addr; s.arlen = 8'(len);
    s.arsize = size; s.arburst = burst; s.arvalid = 1'b1;
    n = 0;
    while (!s.arready && n < 20) begin @(negedge ACLK); n++; end
    chk("ar_ready", 32'(s.arready), 1);
    @(negedge ACLK);
    s.arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (stall) begin
        s.rready = 1'b0;
        @(negedge ACLK);
        chk("r_hold_valid", 32'(s.rvalid), 1);
        chk("r_hold_data", s.rdata, exp_d[i]);
      end
      s.rready = 1'b1;
      chk("r_valid", 32'(s.rvalid), 1);
      chk("r_data", s.rdata, exp_d[i]);
      chk("r_resp", 32'(s.rresp), 32'(exp_r[i]));
      chk("r_id", 32'(s.rid), 32'(id));
      chk("r_last", 32'(s.rlast), 32'(i == len));
      @(negedge ACLK);
    end
    s.rready = 1'b0;
    chk("r_done", 32'(s.rvalid), 0);
    chk("ar_ready_b2b", 32'(s.arready), 1);
  endtask

  initial begin
    s.awid = '0; s.awaddr = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0; s.awvalid = 1'b0;
    s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0; s.wvalid = 1'b0; s.bready = 1'b0;
    s.arid = '0; s.araddr = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0; s.arvalid = 1'b0;
    s.rready = 1'b0;
    #1 ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset values
    chk("rst_awready", 32'(s.awready), 0);
    chk("rst_arready", 32'(s.arready), 0);
    chk("rst_wready",  32'(s.wready), 0);
    chk("rst_bvalid",  32'(s.bvalid), 0);
    chk("rst_rvalid",  32'(s.rvalid), 0);
    chk("rst_rlast",   32'(s.rlast), 0);
    chk("rst_bid",     32'(s.bid), 0);
    chk("rst_bresp",   32'(s.bresp), 0);
    chk("rst_rid",     32'(s.rid), 0);
    chk("rst_rdata",   s.rdata, 0);
    chk("rst_rresp",   32'(s.rresp), 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_awready", 32'(s.awready), 1);
    chk("post_rst_arready", 32'(s.arready), 1);

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); exp_d[i] = 32'hA0 + 32'(i); exp_r[i] = OKAY; end
    wr_burst(4'h3, 32'h10, 3, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    rd_burst(4'h5, 32'h10, 3, 3'd2, INCR, 1'b0);

    // WRAP read from 0x38 over words 0x30..0x3C = 1..4
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    wr_burst(4'h1, 32'h30, 3, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    exp_d[0] = 32'd3; exp_d[1] = 32'd4; exp_d[2] = 32'd1; exp_d[3] = 32'd2;
    rd_burst(4'h2, 32'h38, 3, 3'd2, WRAP, 1'b0);

    // Strobed write
    wd[0] = 32'h0;
    wr_burst(4'h0, 32'h0, 0, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    wd[0] = 32'hDEADBEEF;
    wr_burst(4'h0, 32'h0, 0, 3'd2, INCR, 4'b0101, 1'b0, OKAY);
    exp_d[0] = 32'h00AD00EF; exp_r[0] = OKAY;
    rd_burst(4'h0, 32'h0, 0, 3'd2, INCR, 1'b0);

    // Write crossing the end of memory
    wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    wr_burst(4'h6, 32'h3FC, 1, 3'd2, INCR, 4'hF, 1'b0, SLVERR);
    exp_d[0] = 32'h11111111; exp_r[0] = OKAY;
    exp_d[1] = 32'h0;        exp_r[1] = SLVERR;
    rd_burst(4'h7, 32'h3FC, 1, 3'd2, INCR, 1'b0);
    exp_d[0] = 32'h00AD00EF; exp_r[0] = OKAY;
    rd_burst(4'h0, 32'h0, 0, 3'd2, INCR, 1'b0);

    // Reserved burst type: SLVERR, but data still lands as INCR
    wd[0] = 32'h55; wd[1] = 32'h66;
    wr_burst(4'h8, 32'h40, 1, 3'd2, 2'b11, 4'hF, 1'b0, SLVERR);
    exp_d[0] = 32'h55; exp_d[1] = 32'h66; exp_r[0] = OKAY; exp_r[1] = OKAY;
    rd_burst(4'h9, 32'h40, 1, 3'd2, INCR, 1'b0);

    // WLAST on the wrong beat
    wd[0] = 32'h77; wd[1] = 32'h88;
    wr_burst(4'h1, 32'h48, 1, 3'd2, INCR, 4'hF, 1'b1, SLVERR);

    // Oversized read beat
    exp_d[0] = 32'hA0; exp_r[0] = SLVERR;
    rd_burst(4'h4, 32'h10, 0, 3'd3, INCR, 1'b0);

    // Prefill 0x200..0x21C, then concurrent write and stalled read
    for (int i = 0; i < 8; i++) wd[i] = 32'hC000_0000 + 32'(i);
    wr_burst(4'h2, 32'h200, 7, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = 32'hC000_0000 + 32'(i); exp_r[i] = OKAY; wd[i] = 32'hB0 + 32'(i);
    end
    fork
      wr_burst(4'hA, 32'h100, 7, 3'd2, INCR, 4'hF, 1'b0, OKAY);
      rd_burst(4'hC, 32'h200, 7, 3'd2, INCR, 1'b1);
    join
    for (int i = 0; i < 8; i++) exp_d[i] = 32'hB0 + 32'(i);
    rd_burst(4'hD, 32'h100, 7, 3'd2, INCR, 1'b0);

    // Reset asserted while beat 2 of a LEN=7 read is presented
    s.arid = 4'h3; s.araddr = 32'h200; s.arlen = 8'd7;
    s.arsize = 3'd2; s.arburst = INCR; s.arvalid = 1'b1;
    @(negedge ACLK);
    s.arvalid = 1'b0; s.rready = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("mid_rst_beat2", s.rdata, 32'hC000_0002);
    ARESETn = 1'b0; s.rready = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(s.rvalid), 0);
    chk("mid_rst_rlast", 32'(s.rlast), 0);
    @(negedge ACLK);
    chk("mid_rst_arready_held", 32'(s.arready), 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_arready", 32'(s.arready), 1);
    chk("mid_rst_rvalid_after", 32'(s.rvalid), 0);
    for (int i = 0; i < 4; i++) begin exp_d[i] = 32'hA0 + 32'(i); exp_r[i] = OKAY; end
    rd_burst(4'hE, 32'h10, 3, 3'd2, INCR, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
